// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, error constant and command type for the ALU issue unit
package alu_pkg;

  localparam logic [1:0]  OP_ADD  = 2'b00;
  localparam logic [1:0]  OP_SUB  = 2'b01;
  localparam logic [1:0]  OP_MUL  = 2'b10;
  localparam logic [1:0]  OP_DIV  = 2'b11;
  localparam logic [15:0] DIV_ERR = 16'hFFFF;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } alu_cmd_t;

endpackage

// File: rtl/alu_issue_unit_if.sv
// rtl/alu_issue_unit_if.sv - command/result handshake bundle of the ALU issue unit
interface alu_issue_unit_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
);

  logic                     in_valid;
  logic                     in_ready;
  logic [1:0]               in_op;
  logic [7:0]               in_a;
  logic [7:0]               in_b;
  logic                     out_valid;
  logic                     out_ready;
  logic [15:0]              out_result;
  logic [1:0]               out_op;
  logic                     out_err;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic [CNT_W-1:0]         err_count;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_op, out_err, fifo_count, err_count
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_op, out_err, fifo_count, err_count
  );

endinterface

// File: rtl/ALU.sv
// rtl/ALU.sv - combinational 8x8 ALU: add, sub, mul, div with all-ones on divide-by-zero
module ALU
  import alu_pkg::*;
(
  input  logic [1:0]  op_code,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] result
);

  logic [15:0] a_w;
  logic [15:0] b_w;

  assign a_w = {8'h00, a};
  assign b_w = {8'h00, b};

  always_comb begin
    result = 16'h0000;
    case (op_code)
      OP_ADD:  result = a_w + b_w;
      OP_SUB:  result = a_w - b_w;
      OP_MUL:  result = a_w * b_w;
      default: result = (b == 8'h00) ? DIV_ERR : {8'h00, a / b};
    endcase
  end

endmodule

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - command queue with occupancy count and registered full flag
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  alu_cmd_t                   push_data_i,
  input  logic                       pop_i,
  output alu_cmd_t                   head_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  alu_cmd_t        mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic            full_q;
  logic            push_ok;
  logic            pop_ok;

  // A push while full is dropped; the producer is expected to hold it.
  assign push_ok = push_i && !full_q;
  assign pop_ok  = pop_i && (count_q != '0);
  assign count_d = count_q + CW'(push_ok) - CW'(pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = full_q;
  assign count_o = count_q;

endmodule

// File: rtl/alu_issue_unit.sv
// rtl/alu_issue_unit.sv - buffers ALU commands, issues one per cycle, holds the result in a valid/ready slot
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_issue_unit_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  alu_cmd_t          push_data;
  alu_cmd_t          head;
  logic              empty;
  logic              full;
  logic [CW-1:0]     count;
  logic [15:0]       alu_result;
  logic              slot_free;
  logic              issue;
  logic              head_err;

  logic              out_valid_q;
  logic [15:0]       out_result_q;
  logic [1:0]        out_op_q;
  logic              out_err_q;
  logic [CNT_W-1:0]  err_cnt_q;
  logic [CNT_W-1:0]  err_cnt_d;

  assign push_data = {bus.in_op, bus.in_a, bus.in_b};
  assign slot_free = !out_valid_q || bus.out_ready;
  assign issue     = !empty && slot_free;
  // Flag comes from the head fields, not from decoding the ALU's all-ones result.
  assign head_err  = (head.op == OP_DIV) && (head.b == 8'h00);

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (bus.in_valid),
    .push_data_i (push_data),
    .pop_i       (issue),
    .head_o      (head),
    .empty_o     (empty),
    .full_o      (full),
    .count_o     (count)
  );

  ALU u_alu (
    .op_code (head.op),
    .a       (head.a),
    .b       (head.b),
    .result  (alu_result)
  );

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (issue && head_err && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_result_q <= 16'h0000;
      out_op_q     <= 2'b00;
      out_err_q    <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
      if (issue) begin
        out_valid_q  <= 1'b1;
        out_result_q <= alu_result;
        out_op_q     <= head.op;
        out_err_q    <= head_err;
      end else if (bus.out_ready) begin
        out_valid_q  <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = !full;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_op     = out_op_q;
  assign bus.out_err    = out_err_q;
  assign bus.fifo_count = count;
  assign bus.err_count  = err_cnt_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// tb/tb_alu_issue_unit.sv - directed self-checking bench for alu_issue_unit
module tb_alu_issue_unit;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  alu_issue_unit_if #(.DEPTH(4), .CNT_W(2)) bus ();

  alu_issue_unit #(.DEPTH(4), .CNT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.in_valid = v;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
  endtask

  task automatic send_one(input string tag, input logic [1:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [15:0] res, input logic err);
    drive(1'b1, op, a, b);
    step();
    drive(1'b0, 2'b00, 8'h00, 8'h00);
    chk({tag, "_acc_cnt"}, 32'(bus.fifo_count), 32'd1);
    chk({tag, "_acc_vld"}, 32'(bus.out_valid), 32'd0);
    step();
    chk({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_res"}, 32'(bus.out_result), 32'(res));
    chk({tag, "_op"},  32'(bus.out_op), 32'(op));
    chk({tag, "_err"}, 32'(bus.out_err), 32'(err));
    step();
    chk({tag, "_drain"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_cnt0"},  32'(bus.fifo_count), 32'd0);
  endtask

  logic [1:0]  bp_op  [5];
  logic [7:0]  bp_a   [5];
  logic [7:0]  bp_b   [5];
  logic [15:0] bp_res [5];
  logic [15:0] wr_res [9];

  initial begin
    total = 0;
    bad   = 0;
    bp_op  = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd2};
    bp_a   = '{8'd1, 8'd9, 8'd3, 8'd100, 8'd255};
    bp_b   = '{8'd2, 8'd4, 8'd3, 8'd100, 8'd255};
    bp_res = '{16'd3, 16'd5, 16'd9, 16'd200, 16'hFE01};
    wr_res = '{16'd22, 16'd19, 16'd44, 16'd11, 16'd26, 16'd23, 16'd52, 16'd13, 16'd30};

    rst_n = 1'b0;
    drive(1'b0, 2'b00, 8'h00, 8'h00);
    bus.out_ready = 1'b1;
    step();
    step();
    chk("rst_in_ready",  32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result",    32'(bus.out_result), 32'h0);
    chk("rst_op",        32'(bus.out_op), 32'd0);
    chk("rst_err",       32'(bus.out_err), 32'd0);
    chk("rst_count",     32'(bus.fifo_count), 32'd0);
    chk("rst_errcnt",    32'(bus.err_count), 32'd0);
    rst_n = 1'b1;
    step();

    send_one("add", 2'b00, 8'd10, 8'd5, 16'd15, 1'b0);
    send_one("sub", 2'b01, 8'd20, 8'd8, 16'd12, 1'b0);
    send_one("mul", 2'b10, 8'd12, 8'd10, 16'd120, 1'b0);
    send_one("div", 2'b11, 8'd100, 8'd5, 16'd20, 1'b0);
    send_one("divz", 2'b11, 8'd50, 8'd0, 16'hFFFF, 1'b1);
    chk("divz_errcnt", 32'(bus.err_count), 32'd1);
    send_one("after_divz", 2'b00, 8'd1, 8'd1, 16'd2, 1'b0);
    chk("after_divz_errcnt", 32'(bus.err_count), 32'd1);

    // Backpressure: first command lands in the slot, the next four fill the queue.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, bp_op[i], bp_a[i], bp_b[i]);
      step();
    end
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("full_count",    32'(bus.fifo_count), 32'd4);
    chk("full_vld",      32'(bus.out_valid), 32'd1);
    chk("full_res",      32'(bus.out_result), 32'd3);
    drive(1'b1, 2'b00, 8'd7, 8'd7);
    step();
    step();
    drive(1'b0, 2'b00, 8'h00, 8'h00);
    chk("hold_count", 32'(bus.fifo_count), 32'd4);
    chk("hold_res",   32'(bus.out_result), 32'd3);
    chk("hold_op",    32'(bus.out_op), 32'd0);
    chk("hold_vld",   32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      step();
      chk($sformatf("bp_res%0d", i), 32'(bus.out_result), 32'(bp_res[i]));
      chk($sformatf("bp_op%0d", i),  32'(bus.out_op), 32'(bp_op[i]));
      chk($sformatf("bp_cnt%0d", i), 32'(bus.fifo_count), 32'(4 - i));
      chk($sformatf("bp_rdy%0d", i), 32'(bus.in_ready), 32'd1);
    end
    step();
    chk("bp_drain", 32'(bus.out_valid), 32'd0);

    // Steady push/pop at occupancy one; pointers wrap more than once.
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 2'(i), 8'(20 + i), 8'd2);
      step();
      chk($sformatf("wrap_cnt%0d", i), 32'(bus.fifo_count), 32'd1);
      if (i >= 1) begin
        chk($sformatf("wrap_res%0d", i - 1), 32'(bus.out_result), 32'(wr_res[i - 1]));
      end
    end
    drive(1'b0, 2'b00, 8'h00, 8'h00);
    step();
    chk("wrap_res8",  32'(bus.out_result), 32'(wr_res[8]));
    chk("wrap_cnt_end", 32'(bus.fifo_count), 32'd0);
    step();
    chk("wrap_drain", 32'(bus.out_valid), 32'd0);

    // Reset in the middle of a backlog.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b00, 8'(i), 8'd1);
      step();
    end
    drive(1'b0, 2'b00, 8'h00, 8'h00);
    chk("pre_rst_cnt", 32'(bus.fifo_count), 32'd3);
    chk("pre_rst_vld", 32'(bus.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_vld", 32'(bus.out_valid), 32'd0);
    chk("async_rst_cnt", 32'(bus.fifo_count), 32'd0);
    chk("async_rst_rdy", 32'(bus.in_ready), 32'd1);
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    step();
    step();
    chk("post_rst_vld", 32'(bus.out_valid), 32'd0);
    chk("post_rst_cnt", 32'(bus.fifo_count), 32'd0);

    // Divide-by-zero counter saturates at 3 with a 2-bit counter.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'b11, 8'(i + 1), 8'd0);
      step();
    end
    drive(1'b0, 2'b00, 8'h00, 8'h00);
    step();
    chk("sat_last_err", 32'(bus.out_err), 32'd1);
    chk("sat_last_res", 32'(bus.out_result), 32'hFFFF);
    chk("sat_errcnt",   32'(bus.err_count), 32'd3);
    step();
    chk("sat_hold",     32'(bus.err_count), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
